// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer (start detect, mid-bit sampling, LSB-first assembly, valid/ready holding register).
// Define UART_RX_PARITY_EN to add a parity bit stage with parity_odd / parity_err ports.
module uart_rx_ctrl #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 rx_tick,
    input  logic                 rx_en,
    output logic [DATA_BITS-1:0] dq,
    output logic                 dq_valid,
    input  logic                 dq_ready,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun
`ifdef UART_RX_PARITY_EN
    ,
    input  logic                 parity_odd,
    output logic                 parity_err
`endif
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs, rxs_prev;
    logic [TW-1:0]          tick_cnt, tick_d;
    logic [BW-1:0]          bit_cnt, bit_d;
    logic [DATA_BITS-1:0]   shreg, shreg_d;
    logic                   pend, pend_d, stop_bit, stop_d;
    logic                   par_ok, good, load;

    assign rxs     = sync_q[SYNC_STAGES-1];
    assign rx_busy = state != IDLE;

`ifdef UART_RX_PARITY_EN
    logic par_bit, par_d;
    assign par_ok = (^shreg ^ par_bit) == parity_odd;
`else
    assign par_ok = 1'b1;
`endif

    // pend marks the cycle after the stop sample; the word is judged and delivered there
    assign good = pend & stop_bit & par_ok;
    assign load = good & (~dq_valid | dq_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sync_q <= '1;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            pend     <= 1'b0;
            stop_bit <= 1'b0;
            rxs_prev <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            tick_cnt <= tick_d;
            bit_cnt  <= bit_d;
            shreg    <= shreg_d;
            pend     <= pend_d;
            stop_bit <= stop_d;
            rxs_prev <= rx_tick ? rxs : rxs_prev;
`ifdef UART_RX_PARITY_EN
            par_bit  <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state;
        tick_d  = tick_cnt;
        bit_d   = bit_cnt;
        shreg_d = shreg;
        pend_d  = 1'b0;
        stop_d  = stop_bit;
`ifdef UART_RX_PARITY_EN
        par_d   = par_bit;
`endif
        if (!rx_en) begin
            state_d = IDLE;
            tick_d  = '0;
            bit_d   = '0;
        end else if (rx_tick) begin
            tick_d = tick_cnt + 1'b1;
            case (state)
                IDLE: begin
                    tick_d  = '0;
                    state_d = (rxs_prev & ~rxs) ? START : IDLE;
                end
                START: if (tick_cnt == T_MID) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end
                DATA: if (tick_cnt == T_END) begin
                    tick_d  = '0;
                    shreg_d = {rxs, shreg[DATA_BITS-1:1]};
                    bit_d   = bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_cnt == B_LAST) state_d = PARITY;
`else
                    if (bit_cnt == B_LAST) state_d = STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (tick_cnt == T_END) begin
                    tick_d  = '0;
                    par_d   = rxs;
                    state_d = STOP;
                end
`endif
                STOP: if (tick_cnt == T_END) begin
                    tick_d  = '0;
                    pend_d  = 1'b1;
                    stop_d  = rxs;
                    state_d = IDLE;
                end
                default: begin
                    tick_d  = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq         <= '0;
            dq_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            dq         <= load ? shreg : dq;
            dq_valid   <= load | (dq_valid & ~dq_ready);
            frame_err  <= pend & ~stop_bit;
            overrun    <= good & dq_valid & ~dq_ready;
`ifdef UART_RX_PARITY_EN
            parity_err <= pend & ~par_ok;
`endif
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench for uart_rx_ctrl (OVERSAMPLE=16, rx_tick every 4 clocks, 64 clocks per bit).
module tb_uart_rx_ctrl;
    logic       clk = 1'b0, rst = 1'b1, rxd = 1'b1, rx_tick = 1'b0, rx_en = 1'b1, dq_ready = 1'b0;
    logic [7:0] dq;
    logic       dq_valid, rx_busy, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_odd = 1'b0, parity_err, par_flip = 1'b0;
    int         n_pe = 0;
`endif
    int         n_chk = 0, n_fail = 0;
    int         n_vcyc = 0, n_acc = 0, n_fe = 0, n_ov = 0, n_busy = 0;
    logic [7:0] last_acc = '0;

    uart_rx_ctrl dut (
        .clk(clk), .rst(rst), .rxd(rxd), .rx_tick(rx_tick), .rx_en(rx_en),
        .dq(dq), .dq_valid(dq_valid), .dq_ready(dq_ready), .rx_busy(rx_busy),
        .frame_err(frame_err), .overrun(overrun)
`ifdef UART_RX_PARITY_EN
        , .parity_odd(parity_odd), .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    initial forever begin
        repeat (3) @(posedge clk);
        #1 rx_tick = 1'b1;
        @(posedge clk);
        #1 rx_tick = 1'b0;
    end

    always @(negedge clk) begin
        if (dq_valid) n_vcyc++;
        if (dq_valid && dq_ready) begin
            n_acc++;
            last_acc = dq;
        end
        if (frame_err) n_fe++;
        if (overrun) n_ov++;
        if (rx_busy) n_busy++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) n_pe++;
`endif
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic clr;
        n_vcyc = 0; n_acc = 0; n_fe = 0; n_ov = 0; n_busy = 0;
`ifdef UART_RX_PARITY_EN
        n_pe = 0;
`endif
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        wait_clk(64);
    endtask

    task automatic send_head(input logic [7:0] w);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(w[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^w) ^ parity_odd ^ par_flip);
`endif
    endtask

    task automatic send_frame(input logic [7:0] w, input logic s);
        send_head(w);
        drive_bit(s);
        rxd = 1'b1;
        wait_clk(8);
    endtask

    task automatic test_reset;
        n_chk++; if (dq !== 8'h00) begin n_fail++; $display("FAIL rst_dq: got %h expected 00", dq); end
        n_chk++; if (dq_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dq_valid: got %b expected 0", dq_valid); end
        n_chk++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL rst_rx_busy: got %b expected 0", rx_busy); end
        n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_frame_err: got %b expected 0", frame_err); end
        n_chk++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_frame_a5;
        clr; dq_ready = 1'b1;
        send_frame(8'hA5, 1'b1);
        n_chk++; if (n_acc !== 1) begin n_fail++; $display("FAIL a5_accepts: got %0d expected 1", n_acc); end
        n_chk++; if (last_acc !== 8'hA5) begin n_fail++; $display("FAIL a5_dq: got %h expected a5", last_acc); end
        n_chk++; if (n_vcyc !== 1) begin n_fail++; $display("FAIL a5_valid_cycles: got %0d expected 1", n_vcyc); end
        n_chk++; if (n_fe !== 0) begin n_fail++; $display("FAIL a5_frame_err: got %0d expected 0", n_fe); end
        n_chk++; if (n_ov !== 0) begin n_fail++; $display("FAIL a5_overrun: got %0d expected 0", n_ov); end
        n_chk++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL a5_busy_after: got %b expected 0", rx_busy); end
    endtask

    task automatic test_glitch;
        clr;
        rxd = 1'b0;
        wait_clk(20);
        rxd = 1'b1;
        wait_clk(128);
        n_chk++; if (n_busy == 0) begin n_fail++; $display("FAIL glitch_start_seen: got %0d busy cycles expected >0", n_busy); end
        n_chk++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got %b expected 0", rx_busy); end
        n_chk++; if (n_vcyc !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d expected 0", n_vcyc); end
        n_chk++; if (n_fe !== 0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d expected 0", n_fe); end
    endtask

    task automatic test_frame_err;
        clr; dq_ready = 1'b1;
        send_head(8'h3C);
        drive_bit(1'b0);
        wait_clk(8);
        n_chk++; if (n_fe !== 1) begin n_fail++; $display("FAIL fe_pulse: got %0d cycles expected 1", n_fe); end
        n_chk++; if (n_vcyc !== 0) begin n_fail++; $display("FAIL fe_valid: got %0d expected 0", n_vcyc); end
        clr;
        wait_clk(192);
        n_chk++; if (n_busy !== 0) begin n_fail++; $display("FAIL fe_break_retrigger: got %0d busy cycles expected 0", n_busy); end
        n_chk++; if (n_fe !== 0) begin n_fail++; $display("FAIL fe_break_flags: got %0d expected 0", n_fe); end
        drive_bit(1'b1);
        clr;
        send_frame(8'h5A, 1'b1);
        n_chk++; if (n_acc !== 1) begin n_fail++; $display("FAIL fe_next_accepts: got %0d expected 1", n_acc); end
        n_chk++; if (last_acc !== 8'h5A) begin n_fail++; $display("FAIL fe_next_dq: got %h expected 5a", last_acc); end
    endtask

    task automatic test_overrun;
        int k;
        clr; dq_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        n_chk++; if (dq !== 8'h11) begin n_fail++; $display("FAIL ovr_dq_held: got %h expected 11", dq); end
        n_chk++; if (dq_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b expected 1", dq_valid); end
        n_chk++; if (n_ov !== 1) begin n_fail++; $display("FAIL ovr_pulse: got %0d cycles expected 1", n_ov); end
        clr; dq_ready = 1'b1;
        wait_clk(1);
        dq_ready = 1'b0;
        n_chk++; if (n_acc !== 1 || last_acc !== 8'h11) begin n_fail++; $display("FAIL ovr_drain: got %0d accepts of %h expected 1 of 11", n_acc, last_acc); end
        n_chk++; if (dq_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain_valid: got %b expected 0", dq_valid); end
        send_frame(8'h11, 1'b1);
        clr;
        send_head(8'h22);
        rxd = 1'b1;
        k = 0;
        while (rx_busy && k < 200) begin
            wait_clk(1);
            k++;
        end
        n_chk++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL ovr_stop_wait: got busy %b after %0d clocks expected 0", rx_busy, k); end
        dq_ready = 1'b1;
        wait_clk(1);
        dq_ready = 1'b0;
        n_chk++; if (dq !== 8'h22) begin n_fail++; $display("FAIL same_edge_dq: got %h expected 22", dq); end
        n_chk++; if (dq_valid !== 1'b1) begin n_fail++; $display("FAIL same_edge_valid: got %b expected 1", dq_valid); end
        n_chk++; if (n_ov !== 0) begin n_fail++; $display("FAIL same_edge_overrun: got %0d expected 0", n_ov); end
        n_chk++; if (n_acc !== 1 || last_acc !== 8'h11) begin n_fail++; $display("FAIL same_edge_accept: got %0d accepts of %h expected 1 of 11", n_acc, last_acc); end
        wait_clk(40);
        dq_ready = 1'b1;
        wait_clk(1);
        dq_ready = 1'b0;
        n_chk++; if (last_acc !== 8'h22 || dq_valid !== 1'b0) begin n_fail++; $display("FAIL same_edge_drain: got %h valid %b expected 22 valid 0", last_acc, dq_valid); end
    endtask

    task automatic test_reset_mid;
        clr; dq_ready = 1'b0;
        send_frame(8'h5A, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b1);
        rxd = 1'b1;
        wait_clk(32);
        n_chk++; if (dq_valid !== 1'b1 || rx_busy !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got valid %b busy %b expected 1 1", dq_valid, rx_busy); end
        #2 rst = 1'b1;
        #1;
        n_chk++; if (dq !== 8'h00) begin n_fail++; $display("FAIL rmid_dq: got %h expected 00", dq); end
        n_chk++; if (dq_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", dq_valid); end
        n_chk++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", rx_busy); end
        n_chk++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL rmid_flags: got fe %b ov %b expected 0 0", frame_err, overrun); end
        wait_clk(3);
        rst = 1'b0;
        drive_bit(1'b1);
        clr; dq_ready = 1'b1;
        send_frame(8'h7E, 1'b1);
        n_chk++; if (n_acc !== 1 || last_acc !== 8'h7E) begin n_fail++; $display("FAIL rmid_next: got %0d accepts of %h expected 1 of 7e", n_acc, last_acc); end
        n_chk++; if (n_fe !== 0 || n_ov !== 0) begin n_fail++; $display("FAIL rmid_next_flags: got fe %0d ov %0d expected 0 0", n_fe, n_ov); end
    endtask

    task automatic test_rx_en;
        clr; dq_ready = 1'b1;
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1);
        n_chk++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL en_busy_pre: got %b expected 1", rx_busy); end
        rx_en = 1'b0;
        rxd = 1'b1;
        wait_clk(2);
        n_chk++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL en_abort: got %b expected 0", rx_busy); end
        wait_clk(128);
        rx_en = 1'b1;
        drive_bit(1'b1);
        n_chk++; if (n_acc !== 0 || n_fe !== 0) begin n_fail++; $display("FAIL en_silent_drop: got acc %0d fe %0d expected 0 0", n_acc, n_fe); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        clr; dq_ready = 1'b1; parity_odd = 1'b0; par_flip = 1'b1;
        send_frame(8'h01, 1'b1);
        n_chk++; if (n_pe !== 1) begin n_fail++; $display("FAIL par_err_pulse: got %0d expected 1", n_pe); end
        n_chk++; if (n_vcyc !== 0) begin n_fail++; $display("FAIL par_err_valid: got %0d expected 0", n_vcyc); end
        clr; par_flip = 1'b0;
        send_frame(8'h01, 1'b1);
        n_chk++; if (n_acc !== 1 || last_acc !== 8'h01) begin n_fail++; $display("FAIL par_ok_dq: got %0d accepts of %h expected 1 of 01", n_acc, last_acc); end
        n_chk++; if (n_pe !== 0) begin n_fail++; $display("FAIL par_ok_flag: got %0d expected 0", n_pe); end
    endtask
`endif

    initial begin
        wait_clk(3);
        test_reset;
        rst = 1'b0;
        drive_bit(1'b1);
        test_frame_a5;
        test_glitch;
        test_frame_err;
        test_overrun;
        test_reset_mid;
        test_rx_en;
`ifdef UART_RX_PARITY_EN
        test_parity;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
